// File: rtl/program_counter_unit.sv
// -----------------------------------------------------------------------------
// program_counter_unit
//
// Holds the fetch PC and picks the next one every cycle. A small circular
// return-address stack (RAS) serves call/ret pairs.
//
// Next-PC priority, highest first:
//   trap > stall > ret > call > jump > branch_taken > sequential (pc+4)
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous reset, active low
//   stall          in   hold pc and RAS (trap still wins)
//   trap           in   load TRAP_VECTOR, RAS untouched
//   branch_taken   in   pc <- pc + branch_offset
//   branch_offset  in   [XLEN-1:0] signed byte offset
//   jump           in   pc <- jump_target
//   call           in   pc <- jump_target, push pc+4
//   ret            in   pc <- popped RAS top (pc+4 if the RAS is empty)
//   jump_target    in   [XLEN-1:0] absolute target
//   pc             out  [XLEN-1:0] current pc (registered)
//   pc_plus4       out  [XLEN-1:0] pc+4, combinational, wraps mod 2^XLEN
//   ras_empty      out  RAS holds no entries
//   ras_full       out  RAS holds RAS_DEPTH entries
//   misalign_err   out  one-cycle pulse: the last redirect target had
//                       bits[1:0] != 0 (it was loaded with them cleared)
//   ras_underflow  out  one-cycle pulse: the last ret found the RAS empty
//
// Control inputs are level-sampled on each rising edge. Every redirect
// appears on pc right after the edge that sampled it. No bubble is inserted.
// -----------------------------------------------------------------------------
module program_counter_unit #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]   TRAP_VECTOR  = 'h100,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            trap,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_offset,
    input  logic            jump,
    input  logic            call,
    input  logic            ret,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            misalign_err,
    output logic            ras_underflow
);

    // Pointer indexes RAS_DEPTH slots. The count needs one more bit so it
    // can hold RAS_DEPTH itself.
    localparam int              AW      = $clog2(RAS_DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(RAS_DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] pc_q;
    logic [AW-1:0]   wr_ptr_q;     // next slot to write; top entry is wr_ptr_q-1
    logic [CW-1:0]   count_q;
    logic            misalign_q;
    logic            underflow_q;

    // Entry storage is not reset. Only the pointer and the count are.
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];

    // ------------------------------------------------------------------------
    // Next-state selection
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] ras_top;
    logic [AW-1:0]   top_ptr;
    logic            do_redirect;
    logic            do_push;
    logic            do_pop;
    logic            misalign_next;
    logic            underflow_next;

    assign pc_plus4  = pc_q + XLEN'(4);
    assign top_ptr   = wr_ptr_q - AW'(1);
    assign ras_top   = ras_mem[top_ptr];
    assign ras_empty = (count_q == '0);
    assign ras_full  = (count_q == DEPTH_C);

    always_comb begin
        pc_next         = pc_plus4;
        redirect_target = '0;
        do_redirect     = 1'b0;
        do_push         = 1'b0;
        do_pop          = 1'b0;
        misalign_next   = 1'b0;
        underflow_next  = 1'b0;

        if (trap) begin
            // Trap wins over stall. The RAS and the error pulses stay quiet.
            pc_next = TRAP_VECTOR;
        end else if (stall) begin
            pc_next = pc_q;
        end else if (ret) begin
            // ret also wins over a simultaneous call. Nothing is pushed.
            if (ras_empty) begin
                pc_next        = pc_plus4;
                underflow_next = 1'b1;
            end else begin
                pc_next = ras_top;
                do_pop  = 1'b1;
            end
        end else if (call) begin
            redirect_target = jump_target;
            do_redirect     = 1'b1;
            do_push         = 1'b1;
        end else if (jump) begin
            redirect_target = jump_target;
            do_redirect     = 1'b1;
        end else if (branch_taken) begin
            // Two's-complement add. It wraps naturally at XLEN bits.
            redirect_target = pc_q + branch_offset;
            do_redirect     = 1'b1;
        end

        // The redirect loads with bits[1:0] cleared. Non-zero low bits are flagged.
        if (do_redirect) begin
            pc_next       = {redirect_target[XLEN-1:2], 2'b00};
            misalign_next = |redirect_target[1:0];
        end
    end

    // ------------------------------------------------------------------------
    // PC, RAS bookkeeping and pulse registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_VECTOR;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            misalign_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_next;
            misalign_q  <= misalign_next;
            underflow_q <= underflow_next;

            if (do_push) begin
                // When the RAS is full, wr_ptr_q already points at the oldest
                // entry. The push overwrites that entry and the count saturates.
                wr_ptr_q <= wr_ptr_q + AW'(1);
                if (count_q != DEPTH_C) begin
                    count_q <= count_q + CW'(1);
                end
            end else if (do_pop) begin
                wr_ptr_q <= top_ptr;
                count_q  <= count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_mem[wr_ptr_q] <= pc_plus4;
        end
    end

    assign pc            = pc_q;
    assign misalign_err  = misalign_q;
    assign ras_underflow = underflow_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// -----------------------------------------------------------------------------
// tb_program_counter_unit
//
// Each step drives one cycle of controls and advances a behavioural model.
// The model keeps its RAS as a queue, newest entry at the back. The step
// pushes the model's expected {pc, misalign, underflow, empty, full} onto
// exp_q. After the clock edge the step pops that entry and compares it with
// the DUT. Literal checks from the block's own example scenarios are added on
// top of the model checks.
// -----------------------------------------------------------------------------
module tb_program_counter_unit;

    localparam int          XLEN   = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_V  = 32'h0;
    localparam logic [31:0] TRAP_V = 32'h100;
    localparam int          EW     = 36;

    // ------------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic            stall = 1'b0;
    logic            trap = 1'b0;
    logic            branch_taken = 1'b0;
    logic [XLEN-1:0] branch_offset = '0;
    logic            jump = 1'b0;
    logic            call = 1'b0;
    logic            ret = 1'b0;
    logic [XLEN-1:0] jump_target = '0;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            ras_empty;
    logic            ras_full;
    logic            misalign_err;
    logic            ras_underflow;

    program_counter_unit #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RST_V),
        .TRAP_VECTOR  (TRAP_V),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .trap          (trap),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .call          (call),
        .ret           (ret),
        .jump_target   (jump_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .misalign_err  (misalign_err),
        .ras_underflow (ras_underflow)
    );

    // ------------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    // Each entry is {pc[31:0], misalign, underflow, empty, full}.
    logic [EW-1:0] exp_q[$];

    logic [31:0] m_pc;
    logic [31:0] m_ras[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_idle();
        stall = 1'b0; trap = 1'b0; branch_taken = 1'b0; branch_offset = '0;
        jump = 1'b0; call = 1'b0; ret = 1'b0; jump_target = '0;
    endtask

    // ------------------------------------------------------------------------
    // Driver: one clock cycle of stimulus plus the model update and compare
    // ------------------------------------------------------------------------
    task automatic step(input logic s, input logic tr, input logic br, input logic [31:0] off,
                        input logic j, input logic c, input logic r, input logic [31:0] tgt);
        logic [31:0]   t;
        logic          redir;
        logic          mis;
        logic          unf;
        logic [EW-1:0] e;
        stall = s; trap = tr; branch_taken = br; branch_offset = off;
        jump = j; call = c; ret = r; jump_target = tgt;

        redir = 1'b0; t = '0; mis = 1'b0; unf = 1'b0;
        if (tr) begin
            m_pc = TRAP_V;
        end else if (s) begin
            m_pc = m_pc;
        end else if (r) begin
            if (m_ras.size() == 0) begin
                m_pc = m_pc + 32'd4;
                unf  = 1'b1;
            end else begin
                m_pc = m_ras.pop_back();
            end
        end else if (c) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            t = tgt; redir = 1'b1;
        end else if (j) begin
            t = tgt; redir = 1'b1;
        end else if (br) begin
            t = m_pc + off; redir = 1'b1;
        end else begin
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            m_pc = t & ~32'h3;
            mis  = (t[1:0] != 2'b00);
        end
        exp_q.push_back({m_pc, mis, unf, (m_ras.size() == 0), (m_ras.size() == DEPTH)});

        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("exp_q_underrun", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("pc",            pc,                 e[35:4]);
            check("pc_plus4",      pc_plus4,           e[35:4] + 32'd4);
            check("misalign_err",  32'(misalign_err),  32'(e[3]));
            check("ras_underflow", 32'(ras_underflow), 32'(e[2]));
            check("ras_empty",     32'(ras_empty),     32'(e[1]));
            check("ras_full",      32'(ras_full),      32'(e[0]));
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Assert reset a few ns after an edge so its effect shows with no clock
    // edge in between. Release it well away from the next edge.
    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_async_pc",       pc,                 RST_V);
        check("rst_async_empty",    32'(ras_empty),     32'd1);
        check("rst_async_misalign", 32'(misalign_err),  32'd0);
        check("rst_async_underflow",32'(ras_underflow), 32'd0);
        set_idle();
        m_pc = RST_V;
        m_ras.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst_hold_pc", pc, RST_V);
        #2;
        rst = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        m_pc = RST_V;
        set_idle();
        #2;
        check("reset_pc",    pc,             RST_V);
        check("reset_empty", 32'(ras_empty), 32'd1);
        check("reset_full",  32'(ras_full),  32'd0);
        #10;
        rst = 1'b1;

        // Three idle edges after reset release.
        idle(); check("seq_pc1", pc, 32'h4);
        idle(); check("seq_pc2", pc, 32'h8);
        idle(); check("seq_pc3", pc, 32'hC);
        check("seq_empty", 32'(ras_empty), 32'd1);

        // Backward branch, then a misaligned forward branch.
        idle(); check("at_0x10", pc, 32'h10);
        step(1'b0, 1'b0, 1'b1, -32'sd8, 1'b0, 1'b0, 1'b0, 32'h0);
        check("br_back", pc, 32'h08);
        step(1'b0, 1'b0, 1'b1, 32'h6, 1'b0, 1'b0, 1'b0, 32'h0);
        check("br_misal_pc",    pc,                32'h0C);
        check("br_misal_pulse", 32'(misalign_err), 32'd1);
        idle(); check("misal_one_cycle", 32'(misalign_err), 32'd0);

        // A stalled, misaligned branch must not load and must not pulse.
        step(1'b1, 1'b0, 1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 32'h0);
        check("stall_no_misal", 32'(misalign_err), 32'd0);

        // call / ret round trip, then an underflowing ret.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h20);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h400);
        check("call_pc", pc, 32'h400);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("ret_pc",    pc,             32'h24);
        check("ret_empty", 32'(ras_empty), 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("ret_unf_pc",    pc,                 32'h28);
        check("ret_unf_pulse", 32'(ras_underflow), 32'd1);

        // Five nested calls overflow a four-deep RAS.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'(i) << 8);
        end
        check("nest_full", 32'(ras_full), 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0); check("nest_ret1", pc, 32'h404);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0); check("nest_ret2", pc, 32'h304);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0); check("nest_ret3", pc, 32'h204);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0); check("nest_ret4", pc, 32'h104);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("nest_ret5_pc",  pc,                 32'h108);
        check("nest_ret5_unf", 32'(ras_underflow), 32'd1);

        // call together with ret counts as ret. The RAS is empty here.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h600);
        check("callret_pc",    pc,             32'h10C);
        check("callret_empty", 32'(ras_empty), 32'd1);

        // trap together with ret and call leaves the RAS untouched.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h600);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h700);
        check("trap_all_pc", pc, 32'h100);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("trap_ras_kept", pc, 32'h110);

        // Stall holds a jump. A trap during stall still loads.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h800);
        check("stall_hold", pc, 32'h110);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h800);
        check("stall_trap", pc, 32'h100);

        // Sequential wrap at the top of the address space.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
        check("top_pc",    pc,       32'hFFFF_FFFC);
        check("top_plus4", pc_plus4, 32'h0);
        idle(); check("wrap_pc", pc, 32'h0);

        // Misaligned jump and misaligned call.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h203);
        check("jmp_misal_pc", pc, 32'h200);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h301);

        // Random traffic checked against the model.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] rt;
            logic [31:0] ro;
            rt = $urandom();
            if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
            ro = 32'($urandom_range(0, 255)) - 32'd128;
            step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) == 0, ro,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0, rt);
        end

        // Reset during a pending redirect discards it and clears the RAS.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h500);
        jump = 1'b1;
        jump_target = 32'h700;
        apply_reset();
        idle(); check("post_rst_pc",    pc,             32'h4);
        check("post_rst_empty",         32'(ras_empty), 32'd1);
        idle(); check("post_rst_pc2",   pc,             32'h8);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/program_counter_unit.md
PROGRAM_COUNTER_UNIT -- requirements
Module: program_counter_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC/address width (>=8).
REQ-002 SHALL have parameter RESET_VECTOR, default 0, PC value after reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 32'h00000100, PC loaded on trap.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, >=2).
REQ-005 SHALL have one clock; reset is asynchronous and active-low (ports clk, rst).
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 stall  input  1  hold PC and RAS.
REQ-009 trap  input  1  redirect to TRAP_VECTOR.
REQ-010 branch_taken  input  1  PC-relative redirect.
REQ-011 branch_offset  input  XLEN  signed byte offset added to current pc.
REQ-012 jump  input  1  absolute redirect to jump_target.
REQ-013 call  input  1  absolute redirect to jump_target plus push pc+4.
REQ-014 ret  input  1  redirect to popped RAS top.
REQ-015 jump_target  input  XLEN  absolute target address.
REQ-016 pc  output  XLEN  current PC.
REQ-017 pc_plus4  output  XLEN  pc+4, combinational, mod 2^XLEN.
REQ-018 ras_empty / ras_full  output  1 each  RAS occupancy flags.
REQ-019 misalign_err  output  1  one-cycle pulse, misaligned redirect target.
REQ-020 ras_underflow  output  1  one-cycle pulse, ret with empty RAS.

Function
REQ-021 Next PC SHALL be selected per cycle by fixed priority: trap > stall > ret > call > jump > branch_taken > sequential (pc+4).
REQ-022 trap SHALL load TRAP_VECTOR even while stall=1; RAS unchanged.
REQ-023 stall (no trap) SHALL hold pc and RAS, suppress misalign_err/ras_underflow.
REQ-024 Branch target SHALL be pc+branch_offset, two's-complement, truncated to XLEN (wrap-around).
REQ-025 Sequential increment SHALL wrap 2^XLEN-4 -> 0.
REQ-026 Redirect targets (branch/jump/call) with bits[1:0]!=0 SHALL load with bits[1:0] forced to 0 and assert misalign_err next cycle for exactly one cycle.
REQ-027 call SHALL push pc+4 onto RAS and load jump_target in the same edge.
REQ-028 ret with non-empty RAS SHALL load top entry and pop.
REQ-029 ret with empty RAS SHALL load pc+4 and pulse ras_underflow next cycle for one cycle.
REQ-030 call and ret both high SHALL be treated as ret (priority), no push.
REQ-031 push when full SHALL overwrite oldest entry (circular); count stays RAS_DEPTH, ras_full stays 1.
REQ-032 ras_empty SHALL be 1 iff count=0; ras_full 1 iff count=RAS_DEPTH; both registered-state derived.
REQ-033 Redirect takes effect on the edge where asserted; new pc visible after that edge (1-cycle latency), no bubbles inserted.

Reset
REQ-034 rst low SHALL immediately set pc=RESET_VECTOR, RAS count=0, pointers=0, misalign_err=0, ras_underflow=0, independent of clk.
REQ-035 Reset mid-operation SHALL discard pending redirects and RAS contents; first edge after release resumes sequential from RESET_VECTOR.
REQ-036 RAS entry storage need not be reset; only pointers/count.

Verification (XLEN=32, RESET_VECTOR=0, TRAP_VECTOR=0x100, RAS_DEPTH=4)
REQ-037 Release reset, 3 idle edges -> pc 0,4,8,0xC; ras_empty=1.
REQ-038 pc=0x10, branch_taken, offset=-8 -> pc=0x08; then offset=0x6 -> pc=0x0C, misalign_err pulsed one cycle.
REQ-039 pc=0x20 call jump_target=0x400; at 0x400 ret -> pc=0x24, ras_empty=1; second ret -> pc=0x28, ras_underflow pulse.
REQ-040 5 nested calls from 0x0,0x100..0x400 bases -> ras_full=1; 4 rets return newest 4 addresses, 5th ret underflows.
REQ-041 stall=1 with jump=1 -> pc held; trap=1 during stall -> pc=0x100; rst low mid-cycle -> pc=0 immediately.
REQ-042 pc=0xFFFFFFFC sequential -> pc=0x00000000; trap+ret+call simultaneously -> pc=0x100, RAS unchanged.
